pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage pipeline around hazards the forwarding path cannot resolve.
//  Decides load-use stalls, branch flushes and data-memory wait freezes.
//  Drives the write-enables and bubble/flush controls of PC, IF/ID, ID/EX and EX/MEM.
//  Sits beside the forwarding logic in the EX/ID control path; one instance per core.
// PARAMETERS
//  FLUSH_CYCLES  1    extra cycles held in FLUSH after a taken branch (1..15)
//  MEM_TIMEOUT   255  max consecutive MEM_WAIT cycles before watchdog abort (1..65535)
//  CNT_W         32   width of performance counters (STALL_CNT_EN only)
// PORTS
//  clk           in   1      pipeline clock
//  rst_n         in   1      reset; synchronous, active-low
//  ifid_rs1      in   5      rs1 of instruction in ID
//  ifid_rs2      in   5      rs2 of instruction in ID
//  ifid_uses_rs2 in   1      ID instruction reads rs2 (R/S/B types)
//  idex_rd       in   5      rd of instruction in EX
//  idex_memread  in   1      EX instruction is a load
//  branch_taken  in   1      EX resolved a taken branch/jump this cycle
//  dmem_busy     in   1      data memory not ready; MEM stage must hold
//  pc_write      out  1      PC register enable
//  ifid_write    out  1      IF/ID register enable
//  ifid_flush    out  1      IF/ID loads a NOP
//  idex_bubble   out  1      ID/EX loads a NOP (control bits zeroed)
//  exmem_write   out  1      EX/MEM and MEM/WB register enable
//  mem_timeout   out  1      1-cycle pulse: MEM_WAIT watchdog expired
//  stall_cnt     out  CNT_W  load-use stall cycles (STALL_CNT_EN only)
//  flush_cnt     out  CNT_W  flush cycles (STALL_CNT_EN only)
//  memwait_cnt   out  CNT_W  memory-wait cycles (STALL_CNT_EN only)
// BEHAVIOUR
//  - Outputs are combinational from the state register and current inputs; state/counters update on posedge clk.
//  - States: RESET, RUN, FLUSH, MEM_WAIT.
//  - rst_n=0 at posedge: state<=RESET, counters<=0.
//  - RESET outputs: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_write=0, mem_timeout=0.
//  - RESET -> RUN on first posedge with rst_n=1.
//  - RUN default: all write-enables 1, ifid_flush=0, idex_bubble=0.
//  - RUN priority: dmem_busy > branch_taken > load-use.
//  - RUN, dmem_busy=1: pc_write=ifid_write=exmem_write=0, idex_bubble=0; wait_ctr<=1; next MEM_WAIT.
//  - RUN, branch_taken=1: pc_write=1, ifid_flush=1, idex_bubble=1; flush_ctr<=FLUSH_CYCLES; next FLUSH.
//  - RUN, load-use: pc_write=ifid_write=0, idex_bubble=1; stay RUN. Costs exactly 1 stall cycle.
//    Load-use = idex_memread & idex_rd!=0 & (idex_rd==ifid_rs1 | (ifid_uses_rs2 & idex_rd==ifid_rs2)).
//  - FLUSH: ifid_flush=1, idex_bubble=1, writes enabled; flush_ctr decrements; at flush_ctr==1 next RUN.
//  - FLUSH, dmem_busy=1: MEM_WAIT takes priority, remaining flush cycles are dropped; the flush was already applied.
//  - MEM_WAIT: all write-enables 0; wait_ctr increments.
//    dmem_busy=0 -> next RUN; the held instruction re-evaluates hazards in that cycle.
//    wait_ctr==MEM_TIMEOUT with dmem_busy=1 -> mem_timeout=1 for that cycle; next RUN.
//  - Watchdog counter saturates; it never wraps.
//  - branch_taken is ignored in MEM_WAIT; EX is frozen, so it re-asserts after release.
//  - rst_n=0 in any state overrides all transitions.
// CONFIGURATION
//  STALL_CNT_EN defined: three CNT_W counters.
//    Increment on RUN load-use cycles / FLUSH and branch cycles / MEM_WAIT cycles.
//    Counters wrap modulo 2^CNT_W and clear on reset.
//  STALL_CNT_EN undefined: counter ports absent; no counter logic is synthesised.
// STRUCTURE
//  hazard_pkg: state enum (RESET, RUN, FLUSH, MEM_WAIT), REG_X0=5'd0, NOP control constant.
//  Sub-module hazard_perf_counter (enable, wrap, clear), instanced 3x under STALL_CNT_EN.
// TESTING
//  1. Reset held 3 cycles, then released -> RESET outputs while low; RUN with all enables 1 one cycle after release.
//  2. idex_memread=1, idex_rd=5, ifid_rs2=5, ifid_uses_rs2=1 -> exactly 1 cycle of pc_write=0/idex_bubble=1.
//     Repeat with idex_rd=0, or ifid_uses_rs2=0 -> no stall.
//  3. branch_taken=1 with FLUSH_CYCLES=1 -> 2 consecutive cycles of ifid_flush=1, then RUN.
//  4. dmem_busy=1 for 4 cycles -> 4 cycles with all write-enables 0, resume on cycle 5.
//     branch_taken+dmem_busy in the same cycle -> MEM_WAIT first.
//  5. MEM_TIMEOUT=8, dmem_busy held high -> mem_timeout pulses once on the 8th wait cycle, then returns to RUN.
//  6. STALL_CNT_EN, CNT_W=4: 17 load-use stalls -> stall_cnt=1 (wrap).
//     Mid-MEM_WAIT reset -> counters 0, state RESET.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_e  : controller states (RESET, RUN, FLUSH, MEM_WAIT)
//   ctrl_t   : packed bundle of the five pipeline-register controls
//   CTRL_*   : fixed control patterns; CTRL_NOP is the reset/NOP pattern
//   load_use : load-use hazard detect for the instruction sitting in ID
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_FLUSH,
        ST_MEM_WAIT
    } state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Bit order: pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_write;
    } ctrl_t;

    // NOP into IF/ID and ID/EX, nothing advances
    localparam ctrl_t CTRL_NOP    = 5'b00110;
    localparam ctrl_t CTRL_RUN    = 5'b11001;
    // Hold PC and IF/ID, inject one bubble into EX
    localparam ctrl_t CTRL_STALL  = 5'b00011;
    // Fetch the branch target while squashing the wrong-path instructions
    localparam ctrl_t CTRL_FLUSH  = 5'b11111;
    // Whole pipeline frozen behind the data memory
    localparam ctrl_t CTRL_FREEZE = 5'b00000;

    function automatic logic load_use(input logic       memread,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2,
                                      input logic       uses_rs2);
        return memread && (rd != REG_X0) &&
               ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Wrapping event counter, cleared by the synchronous reset.
//   clk, rst_n : clock, synchronous active-low clear
//   en_i       : count this cycle
//   cnt_o      : current count, wraps modulo 2^W
module hazard_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)     cnt_q <= '0;
        else if (en_i)  cnt_q <= cnt_q + W'(1);
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and
// data-memory freezes for a 5-stage pipeline.
//   Inputs : clk, rst_n (sync, active-low), ID source regs, EX rd/memread,
//            branch_taken, dmem_busy
//   Outputs: pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write,
//            mem_timeout (one-cycle watchdog pulse)
// Optional: define STALL_CNT_EN to add stall_cnt, flush_cnt and memwait_cnt
// performance counters (CNT_W bits, wrapping).
// Outputs are combinational from the state register and current inputs.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_uses_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_memread,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             mem_timeout
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
`endif
);

    state_e      state_q, state_d;
    logic [3:0]  flush_q, flush_d;
    logic [15:0] wait_q,  wait_d;
    ctrl_t       ctrl;
    logic        lu;

    assign lu = load_use(idex_memread, idex_rd, ifid_rs1, ifid_rs2, ifid_uses_rs2);

    always_comb begin
        ctrl        = CTRL_RUN;
        mem_timeout = 1'b0;
        state_d     = state_q;
        flush_d     = flush_q;
        wait_d      = wait_q;
        case (state_q)
            ST_RESET: begin
                ctrl    = CTRL_NOP;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (dmem_busy) begin
                    ctrl    = CTRL_FREEZE;
                    wait_d  = 16'd1;
                    state_d = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    ctrl    = CTRL_FLUSH;
                    flush_d = 4'(FLUSH_CYCLES);
                    state_d = ST_FLUSH;
                end else if (lu) begin
                    ctrl    = CTRL_STALL;
                end
            end
            ST_FLUSH: begin
                // The squash already happened on the branch cycle, so a
                // memory stall can simply abandon the remaining flush cycles.
                if (dmem_busy) begin
                    ctrl    = CTRL_FREEZE;
                    wait_d  = 16'd1;
                    state_d = ST_MEM_WAIT;
                end else begin
                    ctrl = CTRL_FLUSH;
                    if (flush_q <= 4'd1) state_d = ST_RUN;
                    else                 flush_d = flush_q - 4'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_busy) begin
                    ctrl = CTRL_FREEZE;
                    if (wait_q != 16'hFFFF) wait_d = wait_q + 16'd1;
                    if (wait_q == 16'(MEM_TIMEOUT)) begin
                        mem_timeout = 1'b1;
                        state_d     = ST_RUN;
                    end
                end else begin
                    // Release cycle: the held ID instruction is checked for
                    // load-use again; branch_taken is stale here and ignored.
                    state_d = ST_RUN;
                    if (lu) ctrl = CTRL_STALL;
                end
            end
            default: begin
                ctrl    = CTRL_NOP;
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
            flush_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            wait_q  <= wait_d;
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign exmem_write = ctrl.exmem_write;

`ifdef STALL_CNT_EN
    // Event classes are recovered from the control pattern; the RESET
    // pattern looks like a stall/flush/freeze, so it is masked out.
    logic active, stall_ev, flush_ev, memwait_ev;
    assign active     = (state_q != ST_RESET);
    assign stall_ev   = active && !ctrl.pc_write && ctrl.idex_bubble;
    assign flush_ev   = active && ctrl.ifid_flush;
    assign memwait_ev = active && !ctrl.exmem_write;

    hazard_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .en_i(stall_ev),   .cnt_o(stall_cnt));
    hazard_perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst_n(rst_n), .en_i(flush_ev),   .cnt_o(flush_cnt));
    hazard_perf_counter #(.W(CNT_W)) u_memwait_cnt (
        .clk(clk), .rst_n(rst_n), .en_i(memwait_ev), .cnt_o(memwait_cnt));
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: one table row per clock cycle,
// expected controls queued on drive and popped at the sample point.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic       ifid_uses_rs2, idex_memread, branch_taken, dmem_busy;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, mem_timeout;
`ifdef STALL_CNT_EN
    logic [3:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_rd(idex_rd), .idex_memread(idex_memread),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_write(exmem_write), .mem_timeout(mem_timeout)
`ifdef STALL_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
`endif
    );

    // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, mem_timeout}
    localparam logic [5:0] E_RST = 6'b001100;
    localparam logic [5:0] E_RUN = 6'b110010;
    localparam logic [5:0] E_STL = 6'b000110;
    localparam logic [5:0] E_BR  = 6'b111110;
    localparam logic [5:0] E_FRZ = 6'b000000;
    localparam logic [5:0] E_TO  = 6'b000001;

    typedef struct {
        logic       rst_n;
        logic [4:0] rs1, rs2, rd;
        logic       uses, mr, br, busy;
        logic [5:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [5:0] sb[$];

    function automatic void add(logic r, logic [4:0] rs1, logic [4:0] rs2, logic uses,
                                logic [4:0] rd, logic mr, logic br, logic busy,
                                logic [5:0] exp);
        vec_t v;
        v.rst_n = r; v.rs1 = rs1; v.rs2 = rs2; v.uses = uses; v.rd = rd;
        v.mr = mr; v.br = br; v.busy = busy; v.exp = exp;
        tbl.push_back(v);
    endfunction

    function automatic void idle(logic [5:0] exp);
        add(1, 0, 0, 0, 0, 0, 0, 0, exp);
    endfunction

    function automatic void busy(logic [5:0] exp);
        add(1, 0, 0, 0, 0, 0, 0, 1, exp);
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst_n = v.rst_n; ifid_rs1 = v.rs1; ifid_rs2 = v.rs2; ifid_uses_rs2 = v.uses;
        idex_rd = v.rd; idex_memread = v.mr; branch_taken = v.br; dmem_busy = v.busy;
        sb.push_back(v.exp);
    endtask

    task automatic check_ctrl(input int row);
        logic [5:0] got, want;
        #2;
        got  = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, mem_timeout};
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL row%0d ctrl got %b want %b", row, got, want);
        end
    endtask

`ifdef STALL_CNT_EN
    task automatic check_cnt(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask
`endif

    initial begin
        // Reset held, then released
        add(0, 0, 0, 0, 0, 0, 0, 0, E_RST);
        add(0, 0, 0, 0, 0, 0, 0, 0, E_RST);
        add(0, 0, 0, 0, 0, 0, 0, 0, E_RST);
        idle(E_RST);
        idle(E_RUN);
        // Load-use on rs2: exactly one stall cycle
        add(1, 3, 5, 1, 5, 1, 0, 0, E_STL);
        idle(E_RUN);
        // rd = x0 and rs2 not used: no stall
        add(1, 0, 0, 1, 0, 1, 0, 0, E_RUN);
        add(1, 3, 5, 0, 5, 1, 0, 0, E_RUN);
        // Load-use on rs1, then same regs without memread
        add(1, 7, 2, 0, 7, 1, 0, 0, E_STL);
        add(1, 7, 2, 0, 7, 0, 0, 0, E_RUN);
        // Branch: two flush cycles then RUN
        add(1, 0, 0, 0, 0, 0, 1, 0, E_BR);
        idle(E_BR);
        idle(E_RUN);
        // dmem_busy 4 cycles, resume on the 5th
        for (int i = 0; i < 4; i++) busy(E_FRZ);
        idle(E_RUN);
        // Branch together with busy: memory wait wins, branch ignored while waiting
        add(1, 0, 0, 0, 0, 0, 1, 1, E_FRZ);
        add(1, 0, 0, 0, 0, 0, 1, 1, E_FRZ);
        add(1, 0, 0, 0, 0, 0, 1, 0, E_RUN);
        add(1, 0, 0, 0, 0, 0, 1, 0, E_BR);
        // Busy during FLUSH drops the remaining flush cycle
        busy(E_FRZ);
        idle(E_RUN);
        idle(E_RUN);
        // Release cycle re-evaluates load-use
        busy(E_FRZ);
        add(1, 9, 0, 0, 9, 1, 0, 0, E_STL);
        idle(E_RUN);
        // Watchdog: entry cycle plus 8 wait cycles, pulse on the 8th
        busy(E_FRZ);
        for (int i = 0; i < 7; i++) busy(E_FRZ);
        busy(E_TO);
        idle(E_RUN);
        // Reset in the middle of a memory wait
        busy(E_FRZ);
        busy(E_FRZ);
        add(0, 0, 0, 0, 0, 0, 0, 1, E_FRZ);
        idle(E_RST);
        idle(E_RUN);

        rst_n = 0; ifid_rs1 = 0; ifid_rs2 = 0; ifid_uses_rs2 = 0;
        idex_rd = 0; idex_memread = 0; branch_taken = 0; dmem_busy = 0;
        @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            check_ctrl(i);
        end

`ifdef STALL_CNT_EN
        // Counters clear on reset, then 17 stalls wrap a 4-bit counter to 1
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        #2;
        check_cnt("stall_cnt_rst", stall_cnt, 4'd0);
        check_cnt("flush_cnt_rst", flush_cnt, 4'd0);
        check_cnt("memwait_cnt_rst", memwait_cnt, 4'd0);
        rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            idex_memread = 1; idex_rd = 4; ifid_rs1 = 4;
            @(negedge clk);
            idex_memread = 0;
        end
        #2;
        check_cnt("stall_cnt_wrap", stall_cnt, 4'd1);
        check_cnt("flush_cnt_idle", flush_cnt, 4'd0);
        check_cnt("memwait_cnt_idle", memwait_cnt, 4'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
